ssm_rr_sched: RTL and testbench
===============================

# ssm_rr_sched

Round-robin scheduler that shares one segmented static approximate multiplier (SSM) core among `NREQ` requesters. It accepts per-requester operand pairs over valid/ready handshakes and registers the winning pair. It then runs the combinational SSM core and registers the result, returning it on a single shared response channel tagged with the requester index and a caller tag. It sits between the accelerator's request ports and the SSM datapath, so the approximate multiplier is the only arithmetic resource.

## Interface
- `N`, 16: operand width; must match the SSM core.
- `M`, 8: SSM segment width; must match the SSM core.
- `NREQ`, 4: number of requesters, 2..8.
- `TAGW`, 4: caller tag width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*N  operand A, requester i at `[i*N +: N]`, unsigned.
- `req_b`  in  NREQ*N  operand B, same packing.
- `req_tag`  in  NREQ*TAGW  caller tag, requester i at `[i*TAGW +: TAGW]`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  clog2(NREQ)  index of the originating requester.
- `rsp_tag`  out  TAGW  tag of the originating request.
- `rsp_result`  out  2N  SSM product.
- `inflight`  out  2  number of occupied stages (0..2).

## Operation
- Two stages:
  - S1 is the operand register: valid, a, b, id, tag.
  - S2 is the result register: valid, result, id, tag.
  - `rsp_*` are driven directly from S2.
- `adv2 = !S2.valid | rsp_ready`. `adv1 = !S1.valid | adv2`.
- Arbitration is combinational each cycle:
  - Search `req_valid` starting at pointer `ptr` and wrapping modulo NREQ.
  - The first set bit wins. `req_ready[win] = adv1`; all other `req_ready` bits are 0.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Handshake on requester i (`req_valid[i] & req_ready[i]`):
  - S1 loads a, b, i, tag.
  - `ptr <= (i+1) mod NREQ`.
  - `ptr` changes only on a handshake.
- If `adv1` is high and there is no handshake, S1.valid clears.
- If `adv2` is high, S2 loads the SSM output of S1's operands together with S1's id, tag and valid.
- Stall: if `rsp_valid & !rsp_ready`, S2 holds, S1 holds if valid, and all `req_ready` are 0 when S1 is valid. Held outputs stay bit-stable.
- `inflight = S1.valid + S2.valid`.
- Arithmetic is unsigned. The result is exactly the SSM core's 2N-bit output; no rounding or saturation is added here. Upper bits are never truncated.
- Reset, including mid-operation:
  - S1.valid and S2.valid go to 0 and `ptr` goes to 0.
  - `rsp_valid`, `req_ready` and `inflight` read 0 during and after reset.
  - `rsp_result`, `rsp_id` and `rsp_tag` read 0.
  - In-flight requests are discarded and not replayed.

## Timing
- Latency: handshake at edge T gives `rsp_valid` from edge T+2, with no stall.
- Throughput: 1 request per cycle with `rsp_ready` held high.
- A response handshake and a new S1→S2 transfer may occur in the same cycle.
- Pipeline full with `rsp_ready` low: zero acceptance until `rsp_ready` rises. On that cycle `req_ready` may already be high, because `adv1` follows `adv2`.
- No combinational path from `req_*` to `rsp_*`. There is a combinational path from `rsp_ready` to `req_ready` (two levels).
- Critical path: S1 register → SSM core → S2 register.

## Structure
- The shared package `ssm_pkg` holds:
  - `N`/`M` defaults,
  - `ID_W = $clog2(NREQ)`,
  - the S1/S2 stage record typedef `{valid, a, b, id, tag}` / `{valid, result, id, tag}`.
- Sub-module `rr_arb`: parametric round-robin arbiter. Inputs are `req`, `ptr` and `en`; outputs are the one-hot `gnt` and the encoded `idx`. It is purely combinational; `ptr` is owned by the parent.
- The SSM core is instantiated unchanged with `N`/`M` and is not registered internally.

## Test plan
- Single request, `rsp_ready=1`: req0 a=0x0003 b=0x0005 tag=0x7 → 2 cycles later `rsp_valid=1`, result=0x0000000F, id=0, tag=0x7.
- High segment: req2 a=0xFFFF b=0xFFFF → result=0xFE010000, id=2. Middle segment: req1 a=0x0100 b=0x0100 → result=0x00010000.
- Fairness: all four requesters valid continuously, `rsp_ready=1` → grant order 0,1,2,3,0,1… and responses id 0,1,2,3,… back-to-back with `inflight=2` in steady state.
- Backpressure: fill both stages, then drop `rsp_ready` for 3 cycles.
  - `rsp_*` stay stable and all `req_ready` are 0.
  - On release, both results emerge in order with no loss or duplication.
- Pointer hold: only req3 valid, granted → `ptr=0`. Next, req1 and req3 both valid → req1 granted first.
- Reset mid-operation: assert `rst_n=0` with `inflight=2` → `rsp_valid`, `req_ready` and `inflight` go to 0 immediately. After release, a new req0 is granted first and its response arrives at T+2.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared types and defaults for the SSM datapath and its round-robin front end.
// The stage records are sized from the package defaults.
package ssm_pkg;
    localparam int SSM_N    = 16;
    localparam int SSM_M    = 8;
    localparam int NREQ_DEF = 4;
    localparam int TAGW_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [SSM_N-1:0]    a;
        logic [SSM_N-1:0]    b;
        logic [ID_W-1:0]     id;
        logic [TAGW_DEF-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic                valid;
        logic [2*SSM_N-1:0]  result;
        logic [ID_W-1:0]     id;
        logic [TAGW_DEF-1:0] tag;
    } s2_t;

    function automatic int rr_next(input int i, input int n);
        return (i + 1 == n) ? 0 : i + 1;
    endfunction
endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter; search starts at ptr and wraps.
// idx is valid whenever any req is set, gnt only when en is high.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        if (en && found)
            gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/ssm_core.sv
// Segmented static approximate multiplier: each operand is reduced to one M-bit
// window (high, middle or low), the windows are multiplied and shifted back.
module ssm_core #(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int SH_HI  = N - M;
    localparam int SH_MID = (N - M) / 2;
    localparam int SW     = $clog2(2 * N);

    // Returns {shift, window}; the topmost nonzero region decides the window.
    function automatic logic [SW+M-1:0] pick(input logic [N-1:0] x);
        logic [SW+M-1:0] r;
        if (|x[N-1 -: SH_MID])
            r = {SW'(SH_HI), x[N-1 -: M]};
        else if (|x[N-1:M])
            r = {SW'(SH_MID), x[SH_MID +: M]};
        else
            r = {SW'(0), x[M-1:0]};
        return r;
    endfunction

    logic [SW+M-1:0] pa, pb;
    logic [2*M-1:0]  pp;

    assign pa = pick(a);
    assign pb = pick(b);
    assign pp = pa[M-1:0] * pb[M-1:0];
    assign p  = {{(2*N-2*M){1'b0}}, pp} << (pa[SW+M-1:M] + pb[SW+M-1:M]);
endmodule

// File: rtl/ssm_rr_sched.sv
// Round-robin scheduler sharing one SSM core: S1 operand register, S2 result
// register, single tagged response channel with valid/ready backpressure.
module ssm_rr_sched
    import ssm_pkg::*;
#(
    parameter int N    = SSM_N,
    parameter int M    = SSM_M,
    parameter int NREQ = NREQ_DEF,
    parameter int TAGW = TAGW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_a,
    input  logic [NREQ*N-1:0]        req_b,
    input  logic [NREQ*TAGW-1:0]     req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [TAGW-1:0]          rsp_tag,
    output logic [2*N-1:0]           rsp_result,
    output logic [1:0]               inflight
);
    s1_t             s1_q;
    s2_t             s2_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] win;
    logic            adv1, adv2, hs;
    logic [2*N-1:0]  prod;

    assign adv2 = !s2_q.valid | rsp_ready;
    assign adv1 = !s1_q.valid | adv2;

    // rst_n gating keeps req_ready low while reset is held.
    rr_arb #(.NREQ(NREQ), .IW(ID_W)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (adv1 & rst_n),
        .gnt (req_ready),
        .idx (win)
    );

    assign hs = |req_ready;

    ssm_core #(.N(N), .M(M)) u_core (
        .a (s1_q.a),
        .b (s1_q.b),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            ptr_q <= '0;
        end else begin
            if (hs) begin
                s1_q  <= '{valid: 1'b1,
                           a:     req_a[win*N +: N],
                           b:     req_b[win*N +: N],
                           id:    win,
                           tag:   req_tag[win*TAGW +: TAGW]};
                ptr_q <= ID_W'(rr_next(int'(win), NREQ));
            end else if (adv1) begin
                s1_q.valid <= 1'b0;
            end
            if (adv2)
                s2_q <= '{valid: s1_q.valid, result: prod, id: s1_q.id, tag: s1_q.tag};
        end
    end

    assign rsp_valid  = s2_q.valid;
    assign rsp_result = s2_q.result;
    assign rsp_id     = s2_q.id;
    assign rsp_tag    = s2_q.tag;
    assign inflight   = {1'b0, s1_q.valid} + {1'b0, s2_q.valid};
endmodule

// File: tb/tb_ssm_rr_sched.sv
// Directed bench for ssm_rr_sched: segment selection, latency, fairness,
// backpressure, pointer hold and mid-operation reset.
module tb_ssm_rr_sched;
    localparam int N    = 16;
    localparam int M    = 8;
    localparam int NREQ = 4;
    localparam int TAGW = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a = '0;
    logic [NREQ*N-1:0]   req_b = '0;
    logic [NREQ*TAGW-1:0] req_tag = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [1:0]          rsp_id;
    logic [TAGW-1:0]     rsp_tag;
    logic [2*N-1:0]      rsp_result;
    logic [1:0]          inflight;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ssm_rr_sched #(.N(N), .M(M), .NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .inflight   (inflight)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [TAGW-1:0] t);
        req_a[i*N +: N]         = a;
        req_b[i*N +: N]         = b;
        req_tag[i*TAGW +: TAGW] = t;
    endtask

    // One request from requester i (others in vmask also raised for arbitration),
    // then the response two edges later and an empty pipe after it drains.
    task automatic single(input string nm, input int i, input logic [NREQ-1:0] vmask,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [TAGW-1:0] t, input logic [2*N-1:0] exp);
        set_op(i, a, b, t);
        req_valid = vmask;
        #1;
        check({nm, "_gnt"}, req_ready, 64'(1) << i);
        tick();
        req_valid = '0;
        #1;
        check({nm, "_lat1"}, rsp_valid, 0);
        tick();
        check({nm, "_vld"}, rsp_valid, 1);
        check({nm, "_res"}, rsp_result, exp);
        check({nm, "_id"}, rsp_id, i);
        check({nm, "_tag"}, rsp_tag, t);
        tick();
        check({nm, "_drain"}, rsp_valid, 0);
    endtask

    initial begin
        // reset state, with a request held during reset
        req_valid = 4'b0001;
        #2;
        check("rst_ready", req_ready, 0);
        tick();
        check("rst_vld", rsp_valid, 0);
        check("rst_infl", inflight, 0);
        check("rst_res", rsp_result, 0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // segment selection and pointer walk
        single("small",  0, 4'b0001, 16'h0003, 16'h0005, 4'h7, 32'h0000_000F);
        single("high",   2, 4'b0100, 16'hFFFF, 16'hFFFF, 4'h3, 32'hFE01_0000);
        single("mid",    1, 4'b0010, 16'h0100, 16'h0100, 4'h2, 32'h0001_0000);
        single("hi_lo",  0, 4'b0001, 16'h1234, 16'h0056, 4'h9, 32'h0006_0C00);
        single("mid_lo", 3, 4'b1000, 16'h0ABC, 16'h0003, 4'hA, 32'h0000_2010);

        // pointer hold: after req3 the pointer wraps to 0, so req1 beats req3
        single("only3",  3, 4'b1000, 16'h0005, 16'h0005, 4'h1, 32'h0000_0019);
        set_op(1, 16'h0002, 16'h0002, 4'h4);
        set_op(3, 16'h0003, 16'h0003, 4'h6);
        req_valid = 4'b1010;
        #1;
        check("p_pick1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        #1;
        check("p_then3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        check("p_rsp1", rsp_id, 1);
        check("p_res1", rsp_result, 32'h4);
        tick();
        check("p_rsp3", rsp_id, 3);
        check("p_res3", rsp_result, 32'h9);
        tick();
        check("p_drain", inflight, 0);

        // fairness: all valid, ptr at 0
        for (int i = 0; i < NREQ; i++)
            set_op(i, N'(i + 1), 16'h0010, TAGW'(i));
        req_valid = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("fair_gnt", req_ready, 64'(1) << (k % 4));
            if (k >= 2) begin
                check("fair_vld", rsp_valid, 1);
                check("fair_id", rsp_id, (k - 2) % 4);
                check("fair_res", rsp_result, ((k - 2) % 4 + 1) * 16);
                check("fair_infl", inflight, 2);
            end
            tick();
        end

        // backpressure: S2 holds id2, S1 holds id3
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", req_ready, 0);
            check("bp_vld", rsp_valid, 1);
            check("bp_id", rsp_id, 2);
            check("bp_res", rsp_result, 32'h30);
            check("bp_infl", inflight, 2);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("rel_id0", rsp_id, 2);
        check("rel_vld0", rsp_valid, 1);
        tick();
        check("rel_id1", rsp_id, 3);
        check("rel_res1", rsp_result, 32'h40);
        check("rel_vld1", rsp_valid, 1);
        tick();
        check("rel_empty", rsp_valid, 0);
        check("rel_infl", inflight, 0);

        // reset with both stages occupied
        set_op(0, 16'h0002, 16'h0003, 4'h1);
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        check("mid_infl", inflight, 2);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("mrst_vld", rsp_valid, 0);
        check("mrst_infl", inflight, 0);
        check("mrst_ready", req_ready, 0);
        check("mrst_res", rsp_result, 0);
        check("mrst_tag", rsp_tag, 0);
        tick();
        check("mrst_vld2", rsp_valid, 0);
        check("mrst_ready2", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        single("post_rst", 0, 4'b1111, 16'h0007, 16'h0009, 4'h5, 32'h0000_003F);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
